bsm_mac: RTL

- Parametrised bit-serial signed/unsigned multiply-accumulate unit; next generation of the BSM bit-serial multiplier.
- Operands arrive LSB-first on two serial bit lines. Widths are selectable at run time up to WMAX.
- Adds a signed/unsigned mode, an accumulate mode, a busy flag and defined restart rules.
- Sits between serial operand sources (bit-stream producers) and any consumer of the OW-bit result.

---
 rtl/bsm_mac.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bsm_mac.sv
// rtl/bsm_mac.sv - bit-serial signed/unsigned multiply-accumulate with run-time widths
// Operands are captured LSB-first, multiplied in FIN, and folded into o in OUT.
module bsm_mac #(
  parameter int WMAX = 16,
  parameter int OW   = 40,
  parameter int WW   = $clog2(WMAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [WW-1:0] wa,
  input  logic [WW-1:0] wb,
  input  logic          signed_mode,
  input  logic          acc_en,
  input  logic          bit_a,
  input  logic          bit_b,
  output logic [OW-1:0] o,
  output logic          done,
  output logic          busy
);

  if (OW < 2 * WMAX) begin : g_ow_check
    $error("bsm_mac: OW must be >= 2*WMAX");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, FIN, OUT} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   n_q, n_d;
  logic [WW-1:0]   wa_q, wa_d;
  logic [WW-1:0]   wb_q, wb_d;
  logic            sgn_q, sgn_d;
  logic            acc_q, acc_d;
  logic [WMAX-1:0] a_q, a_d;
  logic [WMAX-1:0] b_q, b_d;
  logic [OW-1:0]   prod_q, prod_d;
  logic [OW-1:0]   o_q, o_d;
  logic            done_q, done_d;

  logic [WW-1:0]   wa_c, wb_c;

  function automatic logic [WW-1:0] clamp_w(input logic [WW-1:0] w);
    if (w == '0 || int'(w) > WMAX) return WW'(WMAX);
    return w;
  endfunction

  // Only bits below w are ever captured, so bits above it are filled from the sign.
  function automatic logic [OW-1:0] extend(input logic [WMAX-1:0] v, input logic [WW-1:0] w,
                                           input logic sgn);
    logic [OW-1:0] wide;
    logic [OW-1:0] r;
    logic          s;
    wide = OW'(v);
    s    = 1'b0;
    for (int i = 0; i < WMAX; i++) begin
      if (i == int'(w) - 1) s = sgn & v[i];
    end
    for (int i = 0; i < OW; i++) begin
      r[i] = (i < int'(w)) ? wide[i] : s;
    end
    return r;
  endfunction

  assign wa_c = clamp_w(wa);
  assign wb_c = clamp_w(wb);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    wa_d    = wa_q;
    wb_d    = wb_q;
    sgn_d   = sgn_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    o_d     = o_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          wa_d  = wa_c;
          wb_d  = wb_c;
          n_d   = (wa_c > wb_c) ? wa_c : wb_c;
          sgn_d = signed_mode;
          acc_d = acc_en;
          a_d   = '0;
          b_d   = '0;
          a_d[0] = bit_a;
          b_d[0] = bit_b;
          cnt_d = WW'(1);
          state_d = (n_d > WW'(1)) ? SHIFT : FIN;
        end
      end
      SHIFT: begin
        for (int i = 0; i < WMAX; i++) begin
          if (i == int'(cnt_q) && i < int'(wa_q)) a_d[i] = bit_a;
          if (i == int'(cnt_q) && i < int'(wb_q)) b_d[i] = bit_b;
        end
        cnt_d = cnt_q + WW'(1);
        if (cnt_q == n_q - WW'(1)) state_d = FIN;
      end
      FIN: begin
        prod_d  = extend(a_q, wa_q, sgn_q) * extend(b_q, wb_q, sgn_q);
        state_d = OUT;
      end
      OUT: begin
        o_d     = acc_q ? (o_q + prod_q) : prod_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      o_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      o_q     <= o_d;
      done_q  <= done_d;
    end
  end

  assign o    = o_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule
